// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states, oversampling constants and baud divider math.
// Also imported by the transmitter side.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_t;

    localparam int OVERSAMPLE = 16;

    // Three samples around mid-bit; the bit is decided on the last one.
    localparam logic [3:0] SAMPLE_FIRST = 4'd7;
    localparam logic [3:0] SAMPLE_MID   = 4'd8;
    localparam logic [3:0] SAMPLE_LAST  = 4'd9;
    localparam logic [3:0] SCNT_LAST    = 4'd15;

    function automatic int calc_div(input int clock_hz, input int baud_rate);
        return clock_hz / (baud_rate * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divide-by-DIV counter producing a one-cycle oversample tick.
// A synchronous restart realigns the tick phase to an external event.
module uart_baud_tick #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart || cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampling, 2-of-3 mid-bit vote, one-entry output register
// with framing-error and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCK_HZ   = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy,
    output rx_state_t  state_dbg
);

    localparam int DIV = calc_div(CLOCK_HZ, BAUD_RATE);

    generate
        if (DIV < 2) begin : g_div_check
            $error("uart_rx: clock too slow for baud rate, DIV=%0d", DIV);
        end
        if (OVERSAMPLE != uart_pkg::OVERSAMPLE) begin : g_os_check
            $error("uart_rx: only 16x oversampling is supported");
        end
    endgenerate

    logic       rx_meta, rxs, rxs_d;
    logic       tick, start_edge, at_decide, at_last, vote;
    logic       samp_a, samp_b;
    logic [3:0] scnt;
    logic [2:0] bit_idx;
    logic [7:0] shreg;
    logic       shift_en, deliver, frame_bad;
    rx_state_t  state_q, state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end

    assign start_edge = (state_q == ST_IDLE) && rxs_d && !rxs;
    assign at_decide  = tick && (scnt == SAMPLE_LAST);
    assign at_last    = tick && (scnt == SCNT_LAST);
    assign vote       = (samp_a & samp_b) | (samp_a & rxs) | (samp_b & rxs);

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (start_edge),
        .tick    (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_en  = 1'b0;
        deliver   = 1'b0;
        frame_bad = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_edge) state_d = ST_START;
            end
            ST_START: begin
                // A high majority at mid start bit means the falling edge was noise.
                if (at_decide && vote) state_d = ST_IDLE;
                else if (at_last)      state_d = ST_DATA;
            end
            ST_DATA: begin
                shift_en = at_decide;
                if (at_last && bit_idx == 3'd7) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (at_decide) begin
                    if (vote) begin
                        deliver = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        frame_bad = 1'b1;
                        state_d   = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                if (rxs) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scnt    <= 4'd0;
            samp_a  <= 1'b1;
            samp_b  <= 1'b1;
            bit_idx <= 3'd0;
            shreg   <= 8'h00;
        end else begin
            if (start_edge)  scnt <= 4'd0;
            else if (tick)   scnt <= scnt + 4'd1;
            if (tick && scnt == SAMPLE_FIRST) samp_a <= rxs;
            if (tick && scnt == SAMPLE_MID)   samp_b <= rxs;
            if (state_q == ST_START && at_last)     bit_idx <= 3'd0;
            else if (state_q == ST_DATA && at_last) bit_idx <= bit_idx + 3'd1;
            if (shift_en) shreg <= {vote, shreg[7:1]};
        end
    end

    // valid/ready: a byte transfers in any cycle with valid && ready; while valid && !ready,
    // data is frozen and a newly completed byte is dropped with an overrun pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data      <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= frame_bad;
            overrun   <= deliver && valid && !ready;
            if (deliver && (!valid || ready)) begin
                data  <= shreg;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized frame stimulus for uart_rx, checked against a frame-level
// expectation model (byte queue plus pulse counts).
module tb_uart_rx;
    import uart_pkg::*;

    localparam int BIT = 432;

    logic       clk = 1'b0;
    logic       rst, rx, ready;
    logic [7:0] data;
    logic       valid, frame_err, overrun, busy;
    rx_state_t  state_dbg;

    always #5 clk = ~clk;

    uart_rx dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    int fe_cnt = 0, ov_cnt = 0, fe_long = 0, ov_long = 0;
    int vrise_cnt = 0, vcycles = 0, busy_rise = 0, hold_viol = 0;
    int cyc = 0, vrise_cyc = 0, fall_cyc = 0;
    logic       valid_p = 1'b0, fe_p = 1'b0, ov_p = 1'b0, busy_p = 1'b0, hold_p = 1'b0;
    logic [7:0] data_p = 8'h00;

    // Observer on the falling edge: inputs and outputs are both stable for the next posedge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            valid_p <= 1'b0;
            fe_p    <= 1'b0;
            ov_p    <= 1'b0;
            busy_p  <= 1'b0;
            hold_p  <= 1'b0;
            data_p  <= data;
        end else begin
            if (valid && ready) got_q.push_back(data);
            if (valid) vcycles <= vcycles + 1;
            if (valid && !valid_p) begin
                vrise_cnt <= vrise_cnt + 1;
                vrise_cyc <= cyc;
            end
            if (frame_err)         fe_cnt    <= fe_cnt + 1;
            if (frame_err && fe_p) fe_long   <= fe_long + 1;
            if (overrun)           ov_cnt    <= ov_cnt + 1;
            if (overrun && ov_p)   ov_long   <= ov_long + 1;
            if (busy && !busy_p)   busy_rise <= busy_rise + 1;
            if (hold_p && data !== data_p) hold_viol <= hold_viol + 1;
            valid_p <= valid;
            fe_p    <= frame_err;
            ov_p    <= overrun;
            busy_p  <= busy;
            hold_p  <= valid && !ready;
            data_p  <= data;
        end
    end

    int b_got, b_vr, b_fe, b_ov, b_fel, b_ovl, b_vc, b_br, b_hv;

    task automatic snap();
        b_got = got_q.size();
        b_vr  = vrise_cnt;
        b_fe  = fe_cnt;
        b_ov  = ov_cnt;
        b_fel = fe_long;
        b_ovl = ov_long;
        b_vc  = vcycles;
        b_br  = busy_rise;
        b_hv  = hold_viol;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        n_assert++;
        assert (obs >= lo && obs <= hi) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        step(BIT);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v);
        fall_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_v);
    endtask

    initial begin
        logic [7:0] b;
        logic       bad;
        int         gap, exp_fe;

        rst = 1'b1; rx = 1'b1; ready = 1'b1;
        step(3);
        check("rst_data", data, 8'h00);
        check("rst_valid", valid, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_state", state_dbg, ST_IDLE);
        rst = 1'b0;
        step(2 * BIT);

        // basic byte
        snap();
        send_frame(8'h3C, 1'b1);
        step(BIT);
        check("basic_count", got_q.size() - b_got, 1);
        check("basic_data", got_q[b_got], 8'h3C);
        check("basic_valid_cycles", vcycles - b_vc, 1);
        check("basic_frame_err", fe_cnt - b_fe, 0);
        check("basic_overrun", ov_cnt - b_ov, 0);
        check_range("basic_latency", vrise_cyc - fall_cyc, 4104, 4220);
        check("basic_idle", busy, 1'b0);

        // glitch rejection
        snap();
        rx = 1'b0;
        step(40);
        check("glitch_busy_hi", busy, 1'b1);
        rx = 1'b1;
        step(2 * BIT);
        check("glitch_busy_pulse", busy_rise - b_br, 1);
        check("glitch_no_valid", vrise_cnt - b_vr, 0);
        check("glitch_no_fe", fe_cnt - b_fe, 0);
        check("glitch_idle", state_dbg, ST_IDLE);

        // framing error, line held low two bit times
        snap();
        send_frame(8'hA5, 1'b0);
        step(BIT / 2);
        check("fe_break", state_dbg, ST_BREAK);
        check("fe_busy", busy, 1'b1);
        check("fe_pulse", fe_cnt - b_fe, 1);
        check("fe_width", fe_long - b_fel, 0);
        check("fe_no_valid", vrise_cnt - b_vr, 0);
        step(BIT / 2);
        check("fe_still_break", state_dbg, ST_BREAK);
        rx = 1'b1;
        step(BIT);
        check("fe_recovered", busy, 1'b0);

        // overrun
        ready = 1'b0;
        snap();
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        step(BIT / 2);
        check("ovr_valid", valid, 1'b1);
        check("ovr_data", data, 8'h11);
        check("ovr_pulse", ov_cnt - b_ov, 1);
        check("ovr_width", ov_long - b_ovl, 0);
        check("ovr_hold", hold_viol - b_hv, 0);
        check("ovr_no_accept", got_q.size() - b_got, 0);
        ready = 1'b1;
        step(1);
        check("ovr_accept_count", got_q.size() - b_got, 1);
        check("ovr_accept_data", got_q[b_got], 8'h11);
        step(2);
        check("ovr_valid_clear", valid, 1'b0);

        // back-to-back frames
        snap();
        send_frame(8'h55, 1'b1);
        send_frame(8'hAA, 1'b1);
        step(BIT);
        check("b2b_count", got_q.size() - b_got, 2);
        check("b2b_first", got_q[b_got], 8'h55);
        check("b2b_second", got_q[b_got + 1], 8'hAA);
        check("b2b_errors", (fe_cnt - b_fe) + (ov_cnt - b_ov), 0);

        // reset during data bit 4
        b = 8'h3C;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        rx = b[4];
        step(BIT / 2);
        check("mid_busy_before", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("mid_rst_data", data, 8'h00);
        check("mid_rst_valid", valid, 1'b0);
        check("mid_rst_fe", frame_err, 1'b0);
        check("mid_rst_ovr", overrun, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        step(2);
        rst = 1'b0;
        rx  = 1'b1;
        step(BIT);
        snap();
        send_frame(8'h3C, 1'b1);
        step(BIT);
        check("post_rst_count", got_q.size() - b_got, 1);
        check("post_rst_data", got_q[b_got], 8'h3C);

        // randomized frames against the frame-level model
        snap();
        exp_q.delete();
        exp_fe = 0;
        for (int n = 0; n < 6; n++) begin
            b   = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 3) == 0);
            gap = $urandom_range(0, 2);
            if (bad) exp_fe++;
            else     exp_q.push_back(b);
            send_frame(b, !bad);
            if (bad) begin
                drive_bit(1'b0);
                drive_bit(1'b1);
            end
            rx = 1'b1;
            step(gap * BIT);
        end
        step(BIT);
        check("rand_count", got_q.size() - b_got, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("rand_byte%0d", i), got_q[b_got + i], exp_q[i]);
        end
        check("rand_frame_err", fe_cnt - b_fe, exp_fe);
        check("rand_overrun", ov_cnt - b_ov, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
